// File: rtl/pulse_width_checker.sv
// pulse_width_checker
//   Measures the width, in clk cycles, of each high pulse on pulse_in and
//   classifies it against PULSE_DURATION (match / too short / too long).
//   It also keeps a running modulo-256 count of completed pulses.
//
// Parameters
//   PULSE_DURATION : expected pulse width in cycles (1 .. 2**CNT_W-2)
//   CNT_W          : width counter / width output size; saturates at 2**CNT_W-1
//
// Ports
//   clk          : clock, all state on posedge
//   reset        : asynchronous, active-high reset
//   pulse_in     : pulse line under test (may be asynchronous to clk)
//   width        : width of the last completed pulse, held between strobes
//   width_valid  : one-cycle strobe, width and flags updated this cycle
//   match        : last width == PULSE_DURATION
//   too_short    : last width <  PULSE_DURATION
//   too_long     : last width >  PULSE_DURATION (includes saturated widths)
//   saturated    : last pulse reached 2**CNT_W-1 cycles, true width unknown
//   busy         : a pulse is currently being measured
//   pulse_count  : completed pulses, wraps 255 -> 0
module pulse_width_checker #(
  parameter int unsigned PULSE_DURATION = 3,
  parameter int unsigned CNT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             match,
  output logic             too_short,
  output logic             too_long,
  output logic             saturated,
  output logic             busy,
  output logic [7:0]       pulse_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PD      = CNT_W'(PULSE_DURATION);

  typedef enum logic [1:0] {
    S_ARM,
    S_IDLE,
    S_HIGH
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             sync0;
  logic             sync1;
  logic [1:0]       prime;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             done;

  // Two-flop synchronizer for the asynchronous pulse line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= pulse_in;
      sync1 <= sync0;
    end
  end

  // sync1 only reflects the real line two edges after reset release; until
  // then its reset value of 0 would let ARM exit early and a line that was
  // already high would be measured as a partial pulse. prime[1] marks the
  // point where sync1 carries a genuine sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime <= '0;
    end else begin
      prime <= {prime[0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_ARM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ARM: begin
        if (prime[1] && !sync1) begin
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (sync1) begin
          state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!sync1) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_ARM;
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sync1) begin
          cnt_nxt = CNT_ONE;
          sat_nxt = (CNT_ONE == CNT_MAX);
        end
      end
      S_HIGH: begin
        if (sync1) begin
          if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
          sat_nxt = sat | (cnt_nxt == CNT_MAX);
        end else begin
          done    = 1'b1;
          sat_nxt = 1'b0;
        end
      end
      default: begin
        cnt_nxt = cnt;
        sat_nxt = sat;
      end
    endcase
  end

  // Counter and result registers; results only change on a completed pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      sat         <= 1'b0;
      width       <= '0;
      width_valid <= 1'b0;
      match       <= 1'b0;
      too_short   <= 1'b0;
      too_long    <= 1'b0;
      saturated   <= 1'b0;
      pulse_count <= '0;
    end else begin
      cnt         <= cnt_nxt;
      sat         <= sat_nxt;
      width_valid <= done;
      if (done) begin
        width       <= cnt;
        match       <= (cnt == PD);
        too_short   <= (cnt <  PD);
        too_long    <= (cnt >  PD);
        saturated   <= sat;
        pulse_count <= pulse_count + 8'd1;
      end
    end
  end

  assign busy = (state == S_HIGH);

endmodule
